// File: rtl/snn_ni_pkg.sv
// Shared types and defaults for the spike network interface blocks.
`timescale 1ns/1ps
package snn_ni_pkg;

    // Default width of an emitted neuron source address.
    localparam int DEF_NEURON_ADDR_W = 12;

    // Source address at the default width.
    typedef logic [DEF_NEURON_ADDR_W-1:0] addr_t;

    // Serializer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } ni_state_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Finds the lowest set bit of a vector; also reports "any bit set" and
// "exactly one bit set". Purely combinational.
`timescale 1ns/1ps
module lsb_priority_encoder #(
    parameter int WIDTH = 30,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when one bit was set.
    always_comb begin
        any    = |vec;
        single = any && ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/spike_event_serializer.sv
// Collects neuron spikes over a timestep, snapshots them on timestep_end and
// streams one source address per fired neuron, lowest index first.
//
// Stream handshake: an event transfers on a cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_addr and out_last hold their values; out_ready is ignored while
// out_valid is low.
`timescale 1ns/1ps
module spike_event_serializer
    import snn_ni_pkg::*;
#(
    parameter int NUM_INPUTS    = 30,
    parameter int NEURON_ADDR_W = DEF_NEURON_ADDR_W,
    parameter int CNT_W         = $clog2(NUM_INPUTS + 1),
    parameter int IDX_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     enable,
    input  logic                     timestep_end,
    input  logic [NUM_INPUTS-1:0]    spike_in,
    input  logic [NEURON_ADDR_W-1:0] neuron_base,
    output logic [NEURON_ADDR_W-1:0] out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         spike_count,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    ni_state_t                state;
    logic [NUM_INPUTS-1:0]    cap;
    logic [NUM_INPUTS-1:0]    pend;
    logic [NEURON_ADDR_W-1:0] base_q;
    logic [NUM_INPUTS-1:0]    gated_spikes;
    logic [NUM_INPUTS-1:0]    snap;
    logic [IDX_W-1:0]         enc_idx;
    logic                     enc_any;
    logic                     enc_single;
    logic                     accept;

    // Lowest pending neuron and whether it is the final one.
    lsb_priority_encoder #(
        .WIDTH (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec    (pend),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    // Snapshot includes spikes arriving in the same cycle as timestep_end.
    always_comb begin
        gated_spikes = enable ? spike_in : '0;
        snap         = cap | gated_spikes;
    end

    // Stream outputs decode from registered state; the sum wraps at the
    // address width so a base near the top of the space rolls over to zero.
    always_comb begin
        out_valid = (state == ST_DRAIN) && enc_any;
        busy      = (state == ST_DRAIN);
        done      = (state == ST_DONE);
        out_last  = out_valid && enc_single;
        out_addr  = out_valid ? (base_q + NEURON_ADDR_W'(enc_idx)) : '0;
        accept    = out_valid && out_ready;
    end

    // Capture register: accumulate gated spikes, cleared at every boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cap <= '0;
        end else if (timestep_end) begin
            cap <= '0;
        end else begin
            cap <= snap;
        end
    end

    // Control FSM with pending vector, latched base and event counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            pend        <= '0;
            base_q      <= '0;
            spike_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (timestep_end) begin
                        spike_count <= '0;
                        if (snap != '0) begin
                            pend   <= snap;
                            base_q <= neuron_base;
                            state  <= ST_DRAIN;
                        end else begin
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        // Subtract-and-mask drops exactly the lowest set bit.
                        pend        <= pend & (pend - NUM_INPUTS'(1));
                        spike_count <= spike_count + CNT_W'(1);
                        if (enc_single) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a boundary while still serving the last one; set wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun <= 1'b0;
        end else if (timestep_end && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_event_serializer.sv
// Bench for spike_event_serializer: directed timesteps with an address
// scoreboard checked on every cycle the DUT presents an event.
`timescale 1ns/1ps
module tb_spike_event_serializer;
    import snn_ni_pkg::*;

    localparam int N  = 30;
    localparam int AW = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          timestep_end = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic [AW-1:0] neuron_base = '0;
    logic          out_ready = 1'b0;
    logic          clear_overrun = 1'b0;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] spike_count;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    logic [AW:0] exp_q[$];
    logic [AW:0] exp_head;
    int cyc;

    spike_event_serializer dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .enable        (enable),
        .timestep_end  (timestep_end),
        .spike_in      (spike_in),
        .neuron_base   (neuron_base),
        .out_addr      (out_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .spike_count   (spike_count),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected events for a snapshot: ascending index, wrapped address, last flag.
    task automatic push_events(input logic [N-1:0] vec, input logic [AW-1:0] base);
        int total;
        int seen;
        logic [AW-1:0] a;
        total = $countones(vec);
        seen  = 0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                seen++;
                a = base + AW'(i);
                exp_q.push_back({(seen == total) ? 1'b1 : 1'b0, a});
            end
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            cycles++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic spike_cycle(input logic [N-1:0] vec);
        spike_in = vec;
        tick();
        spike_in = '0;
    endtask

    task automatic end_step();
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        spike_in     = '0;
    endtask

    // Scoreboard: every presented event must match the queue head, stalled or not.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'({out_last, out_addr}), 32'hFFFF_FFFF);
            end else begin
                exp_head = exp_q[0];
                if (out_ready) begin
                    chk("event", 32'({out_last, out_addr}), 32'(exp_head));
                    void'(exp_q.pop_front());
                end else begin
                    chk("stalled", 32'({out_last, out_addr}), 32'(exp_head));
                end
            end
        end
    end

    initial begin
        // Reset state.
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_addr", 32'(out_addr), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_count", 32'(spike_count), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Basic timestep: {3,7,29} at base 0x100, back-to-back events.
        neuron_base = 12'h100;
        out_ready   = 1'b1;
        spike_cycle(N'(1) << 3 | N'(1) << 7 | N'(1) << 29);
        push_events(N'(1) << 3 | N'(1) << 7 | N'(1) << 29, 12'h100);
        end_step();
        chk("lat_valid", 32'(out_valid), 32'(1));
        chk("busy_drain", 32'(busy), 32'(1));
        wait_done(10, 1'b0, cyc);
        chk("throughput", 32'(cyc), 32'(3));
        chk("count_3", 32'(spike_count), 32'(3));
        tick();
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("q_empty_1", 32'(exp_q.size()), 32'(0));

        // Backpressure: {0,5} with out_ready toggling.
        spike_cycle(N'(1) << 0 | N'(1) << 5);
        push_events(N'(1) << 0 | N'(1) << 5, 12'h100);
        out_ready = 1'b0;
        end_step();
        wait_done(20, 1'b1, cyc);
        out_ready = 1'b1;
        chk("count_2", 32'(spike_count), 32'(2));
        chk("q_empty_2", 32'(exp_q.size()), 32'(0));
        tick();

        // Empty timestep: done at t+1, no events.
        end_step();
        chk("empty_done", 32'(done), 32'(1));
        chk("empty_valid", 32'(out_valid), 32'(0));
        chk("empty_count", 32'(spike_count), 32'(0));
        tick();
        chk("empty_done_off", 32'(done), 32'(0));

        // Overrun during a full 30-event drain; set beats clear in the same cycle.
        neuron_base = 12'h040;
        spike_cycle('1);
        push_events('1, 12'h040);
        end_step();
        for (int i = 0; i < 5; i++) tick();
        spike_in      = N'(3);
        clear_overrun = 1'b1;
        end_step();
        clear_overrun = 1'b0;
        chk("overrun_set", 32'(overrun), 32'(1));
        wait_done(40, 1'b0, cyc);
        chk("count_30", 32'(spike_count), 32'(30));
        for (int i = 0; i < 5; i++) tick();
        chk("no_second_snap", 32'(out_valid), 32'(0));
        chk("overrun_sticky", 32'(overrun), 32'(1));
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_clear", 32'(overrun), 32'(0));
        chk("q_empty_3", 32'(exp_q.size()), 32'(0));

        // Address wrap at top of address space.
        neuron_base = 12'hFFE;
        spike_cycle(N'(7));
        push_events(N'(7), 12'hFFE);
        end_step();
        wait_done(10, 1'b0, cyc);
        chk("wrap_count", 32'(spike_count), 32'(3));
        chk("q_empty_4", 32'(exp_q.size()), 32'(0));
        tick();

        // Reset mid-drain, then spikes during reset / enable low are dropped.
        neuron_base = 12'h200;
        spike_cycle(N'(6'b111110));
        push_events(N'(6'b111110), 12'h200);
        end_step();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_addr", 32'(out_addr), 32'(0));
        chk("mid_rst_count", 32'(spike_count), 32'(0));
        exp_q.delete();
        spike_cycle(N'(1) << 20);
        rst_n = 1'b1;
        tick();
        enable = 1'b0;
        spike_cycle(N'(1) << 10);
        enable = 1'b1;
        spike_cycle(N'(1) << 6);
        push_events(N'(1) << 6 | N'(1) << 8, 12'h200);
        spike_in = N'(1) << 8;
        end_step();
        wait_done(10, 1'b0, cyc);
        chk("post_rst_count", 32'(spike_count), 32'(2));
        tick();
        chk("q_empty_final", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
